// File: rtl/instr_sequencer.sv
// Purpose: self-running fetch/decode/execute control sequencer driving the datapath, IR, PC and memory port.
// Latency: Moore outputs registered alongside the state (valid the cycle a state is entered); MOV#=5, CMP=7, ADD=8, LDR=9, STR=10 cycles.
// Backpressure: IF1, MEM_RD and MEM_WR stall on mem_ready low; MAX_WAIT consecutive low cycles are tolerated, one more traps into ERROR.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset into RST
//   ir                 instruction register; decode key is ir[15:11] (opcode, op)
//   mem_ready          memory completed the current read/write (only sampled in wait states)
//   load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd   fetch / PC / memory control
//   nsel, write, loada, loadb, loadc, loads, asel, bsel, vsel  register file and datapath control
//   halted, err        sticky terminal status
module instr_sequencer #(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ir,
    input  logic             mem_ready,
    output logic             load_ir,
    output logic             load_pc,
    output logic             reset_pc,
    output logic             addr_sel,
    output logic             load_addr,
    output logic [1:0]       mem_cmd,
    output logic [2:0]       nsel,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic             halted,
    output logic             err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    // Decode keys {opcode, op}
    localparam logic [4:0] K_MOVI = 5'b11010;
    localparam logic [4:0] K_MOVR = 5'b11000;
    localparam logic [4:0] K_ADD  = 5'b10100;
    localparam logic [4:0] K_CMP  = 5'b10101;
    localparam logic [4:0] K_AND  = 5'b10110;
    localparam logic [4:0] K_MVN  = 5'b10111;
    localparam logic [4:0] K_LDR  = 5'b01100;
    localparam logic [4:0] K_STR  = 5'b10000;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
        S_W_IMM, S_GET_A, S_GET_B, S_EXEC, S_EXEC_Z,
        S_WR_REG, S_CMP_S, S_ADDR, S_LD_ADDR, S_GET_D,
        S_PASS, S_MEM_RD, S_W_MEM, S_MEM_WR, S_HALT, S_ERROR
    } state_t;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic [2:0] nsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       halted;
        logic       err;
    } ctrl_t;

    state_t          state;
    state_t          nxt;
    ctrl_t           ctrl_q;
    logic [CW-1:0]   wait_cnt;
    logic [4:0]      op_q;     // decode key captured in DECODE so later steps do not depend on ir
    logic            unused_ir;

    assign unused_ir = ^ir;

    // Control word for each state. EXEC_Z is EXEC with the A operand forced to
    // zero (MOV register / MVN), kept as its own state so outputs stay Moore.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST:     begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            S_IF1:     begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; end
            S_IF2:     begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; c.load_ir = 1'b1; end
            S_UPD_PC:  c.load_pc = 1'b1;
            S_W_IMM:   begin c.nsel = 3'b001; c.vsel = 2'b01; c.write = 1'b1; end
            S_GET_A:   begin c.nsel = 3'b001; c.loada = 1'b1; end
            S_GET_B:   begin c.nsel = 3'b100; c.loadb = 1'b1; end
            S_EXEC:    c.loadc = 1'b1;
            S_EXEC_Z:  begin c.loadc = 1'b1; c.asel = 1'b1; end
            S_WR_REG:  begin c.nsel = 3'b010; c.vsel = 2'b11; c.write = 1'b1; end
            S_CMP_S:   c.loads = 1'b1;
            S_ADDR:    begin c.bsel = 1'b1; c.loadc = 1'b1; end
            S_LD_ADDR: c.load_addr = 1'b1;
            S_GET_D:   begin c.nsel = 3'b010; c.loadb = 1'b1; end
            S_PASS:    begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_MEM_RD:  c.mem_cmd = 2'b01;
            S_W_MEM:   begin c.mem_cmd = 2'b01; c.nsel = 3'b010; c.vsel = 2'b00; c.write = 1'b1; end
            S_MEM_WR:  c.mem_cmd = 2'b10;
            S_HALT:    c.halted = 1'b1;
            S_ERROR:   c.err = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            S_RST:    nxt = S_IF1;
            S_IF1: begin
                if (mem_ready)                  nxt = S_IF2;
                else if (wait_cnt == WAIT_LIM)  nxt = S_ERROR;
            end
            S_IF2:    nxt = S_UPD_PC;
            S_UPD_PC: nxt = S_DECODE;
            S_DECODE: begin
                casez (ir[15:11])
                    K_MOVI:                nxt = S_W_IMM;
                    K_MOVR, K_MVN:         nxt = S_GET_B;
                    K_ADD, K_AND, K_CMP:   nxt = S_GET_A;
                    K_LDR, K_STR:          nxt = S_GET_A;
                    5'b111??:              nxt = S_HALT;
                    default:               nxt = S_ERROR;
                endcase
            end
            S_W_IMM:  nxt = S_IF1;
            S_GET_A:  nxt = (op_q == K_LDR || op_q == K_STR) ? S_ADDR : S_GET_B;
            S_GET_B: begin
                if (op_q == K_CMP)                        nxt = S_CMP_S;
                else if (op_q == K_MOVR || op_q == K_MVN) nxt = S_EXEC_Z;
                else                                      nxt = S_EXEC;
            end
            S_EXEC, S_EXEC_Z: nxt = S_WR_REG;
            S_WR_REG:  nxt = S_IF1;
            S_CMP_S:   nxt = S_IF1;
            S_ADDR:    nxt = S_LD_ADDR;
            S_LD_ADDR: nxt = (op_q == K_STR) ? S_GET_D : S_MEM_RD;
            S_GET_D:   nxt = S_PASS;
            S_PASS:    nxt = S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)                  nxt = S_W_MEM;
                else if (wait_cnt == WAIT_LIM)  nxt = S_ERROR;
            end
            S_W_MEM:   nxt = S_IF1;
            S_MEM_WR: begin
                if (mem_ready)                  nxt = S_IF1;
                else if (wait_cnt == WAIT_LIM)  nxt = S_ERROR;
            end
            S_HALT:    nxt = S_HALT;
            S_ERROR:   nxt = S_ERROR;
            default:   nxt = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_RST;
            ctrl_q   <= ctrl_of(S_RST);
            wait_cnt <= '0;
            op_q     <= '0;
        end else begin
            state  <= nxt;
            ctrl_q <= ctrl_of(nxt);
            if (state == S_DECODE)
                op_q <= ir[15:11];
            // Only wait states loop on themselves with mem_ready low, so any
            // state change is an entry and restarts the count.
            if (nxt != state)
                wait_cnt <= '0;
            else if (!mem_ready && wait_cnt != WAIT_LIM)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign load_ir   = ctrl_q.load_ir;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_addr = ctrl_q.load_addr;
    assign mem_cmd   = ctrl_q.mem_cmd;
    assign nsel      = ctrl_q.nsel;
    assign write     = ctrl_q.write;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign vsel      = ctrl_q.vsel;
    assign halted    = ctrl_q.halted;
    assign err       = ctrl_q.err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Purpose: scoreboard bench for instr_sequencer against a per-instruction step-list model.
// Latency: one expected control word per clock, pushed after the edge and popped on the falling edge.
// Backpressure: mem_ready waits chosen by the stimulus, including the MAX_WAIT boundary and timeout.
module tb_instr_sequencer;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic        load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0]  mem_cmd;
    logic [2:0]  nsel;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel;
    logic        halted, err;

    always #5 clk = ~clk;

    instr_sequencer #(.WIDTH(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready),
        .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
        .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
        .nsel(nsel), .write(write), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .vsel(vsel), .halted(halted), .err(err)
    );

    typedef struct packed {
        logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
        logic [1:0] mem_cmd;
        logic [2:0] nsel;
        logic       write, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] vsel;
        logic       halted, err;
    } out_t;

    out_t act;
    assign act = {load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, nsel,
                  write, loada, loadb, loadc, loads, asel, bsel, vsel, halted, err};

    // Step codes of the reference model
    localparam int C_RST = 0, C_IF1 = 1, C_IF2 = 2, C_UPD = 3, C_DEC = 4, C_WIMM = 5;
    localparam int C_GETA = 6, C_GETB = 7, C_EXEC = 8, C_EXECZ = 9, C_WR = 10, C_CMPS = 11;
    localparam int C_ADDR = 12, C_LDA = 13, C_GETD = 14, C_PASS = 15, C_MRD = 16;
    localparam int C_WMEM = 17, C_MWR = 18, C_HALT = 19, C_ERR = 20;

    int   total = 0;
    int   bad = 0;
    out_t exp_q[$];
    string tag_q[$];
    int   path[$];

    logic [4:0] good_keys[8] = '{5'b11010, 5'b11000, 5'b10100, 5'b10101,
                                 5'b10110, 5'b10111, 5'b01100, 5'b10000};
    logic [4:0] bad_keys[6]  = '{5'b00000, 5'b00101, 5'b01101, 5'b10001, 5'b11001, 5'b11011};

    function automatic out_t expect_of(input int c);
        out_t o;
        o = '0;
        case (c)
            C_RST:   begin o.reset_pc = 1; o.load_pc = 1; end
            C_IF1:   begin o.addr_sel = 1; o.mem_cmd = 2'b01; end
            C_IF2:   begin o.addr_sel = 1; o.mem_cmd = 2'b01; o.load_ir = 1; end
            C_UPD:   o.load_pc = 1;
            C_WIMM:  begin o.nsel = 3'b001; o.vsel = 2'b01; o.write = 1; end
            C_GETA:  begin o.nsel = 3'b001; o.loada = 1; end
            C_GETB:  begin o.nsel = 3'b100; o.loadb = 1; end
            C_EXEC:  o.loadc = 1;
            C_EXECZ: begin o.loadc = 1; o.asel = 1; end
            C_WR:    begin o.nsel = 3'b010; o.vsel = 2'b11; o.write = 1; end
            C_CMPS:  o.loads = 1;
            C_ADDR:  begin o.bsel = 1; o.loadc = 1; end
            C_LDA:   o.load_addr = 1;
            C_GETD:  begin o.nsel = 3'b010; o.loadb = 1; end
            C_PASS:  begin o.asel = 1; o.loadc = 1; end
            C_MRD:   o.mem_cmd = 2'b01;
            C_WMEM:  begin o.mem_cmd = 2'b01; o.nsel = 3'b010; o.write = 1; end
            C_MWR:   o.mem_cmd = 2'b10;
            C_HALT:  o.halted = 1;
            C_ERR:   o.err = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic string name_of(input int c);
        case (c)
            C_RST: return "rst";     C_IF1: return "if1";    C_IF2: return "if2";
            C_UPD: return "upd_pc";  C_DEC: return "decode"; C_WIMM: return "w_imm";
            C_GETA: return "get_a";  C_GETB: return "get_b"; C_EXEC: return "exec";
            C_EXECZ: return "exec_z"; C_WR: return "wr_reg"; C_CMPS: return "cmp_s";
            C_ADDR: return "addr";   C_LDA: return "ld_addr"; C_GETD: return "get_d";
            C_PASS: return "pass";   C_MRD: return "mem_rd"; C_WMEM: return "w_mem";
            C_MWR: return "mem_wr";  C_HALT: return "halt";  C_ERR: return "error";
            default: return "unknown";
        endcase
    endfunction

    // Execute-phase step list per decode key
    function automatic void build_path(input logic [4:0] key);
        path.delete();
        casez (key)
            5'b11010: path = '{C_WIMM};
            5'b11000: path = '{C_GETB, C_EXECZ, C_WR};
            5'b10111: path = '{C_GETB, C_EXECZ, C_WR};
            5'b10100: path = '{C_GETA, C_GETB, C_EXEC, C_WR};
            5'b10110: path = '{C_GETA, C_GETB, C_EXEC, C_WR};
            5'b10101: path = '{C_GETA, C_GETB, C_CMPS};
            5'b01100: path = '{C_GETA, C_ADDR, C_LDA, C_MRD, C_WMEM};
            5'b10000: path = '{C_GETA, C_ADDR, C_LDA, C_GETD, C_PASS, C_MWR};
            5'b111??: path = '{C_HALT};
            default:  path = '{C_ERR};
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: one control word per cycle, sampled on the falling edge
    initial begin
        forever begin
            out_t  e;
            string t;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, 32'(act), 32'(e));
            end
        end
    end

    // Consumes one cycle: expectation for the current state, inputs for its edge
    task automatic step(input int c, input logic mr);
        mem_ready = mr;
        exp_q.push_back(expect_of(c));
        tag_q.push_back(name_of(c));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input int c, input int lows, output bit timed_out);
        int n;
        n = (lows > MAX_WAIT) ? MAX_WAIT + 1 : lows;
        for (int k = 0; k < n; k++) step(c, 1'b0);
        timed_out = (lows > MAX_WAIT);
        if (!timed_out) step(c, 1'b1);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 check("async_reset", 32'(act), 32'(expect_of(C_RST)));
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", 32'(act), 32'(expect_of(C_RST)));
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic terminal(input int c, input int n);
        repeat (n) begin
            ir = 16'($urandom);
            step(c, rbit());
        end
        do_reset();
    endtask

    task automatic run_instr(input logic [15:0] iv, input int lows_if, input int lows_mem,
                             input int abort_at);
        bit to;
        ir = iv;
        wait_step(C_IF1, lows_if, to);
        if (to) begin terminal(C_ERR, 4); return; end
        step(C_IF2, rbit());
        step(C_UPD, rbit());
        step(C_DEC, rbit());
        build_path(iv[15:11]);
        foreach (path[i]) begin
            if (i == abort_at) begin do_reset(); return; end
            if (path[i] == C_MRD || path[i] == C_MWR) begin
                wait_step(path[i], lows_mem, to);
                if (to) begin terminal(C_ERR, 4); return; end
            end else if (path[i] == C_HALT || path[i] == C_ERR) begin
                terminal(path[i], (path[i] == C_HALT) ? 20 : 5);
                return;
            end else begin
                step(path[i], rbit());
            end
        end
    endtask

    initial begin
        #1;
        do_reset();
        run_instr(16'hD105, 0, 0, -1);            // MOV R1,#5
        run_instr(16'hA2A3, 0, 0, -1);            // ADD R5,R2,R3
        run_instr(16'h6220, 0, 3, -1);            // LDR, 3 wait cycles
        run_instr(16'h8220, 1, 2, -1);            // STR
        run_instr(16'hA823, 0, 0, -1);            // CMP
        run_instr(16'hB123, 0, 0, -1);            // AND
        run_instr(16'hB865, 0, 0, -1);            // MVN
        run_instr(16'hC047, 0, 0, -1);            // MOV register
        run_instr(16'hA2A3, 0, 0, 2);             // ADD aborted in EXEC
        run_instr(16'hD105, MAX_WAIT, 0, -1);     // fetch ready on the last allowed cycle
        run_instr(16'h6220, 0, MAX_WAIT, -1);     // read ready on the last allowed cycle
        run_instr(16'h8220, 0, MAX_WAIT + 1, -1); // write timeout
        run_instr(16'hD105, MAX_WAIT + 1, 0, -1); // fetch timeout
        run_instr(16'hE000, 0, 0, -1);            // HALT
        run_instr(16'h0000, 0, 0, -1);            // undefined encoding
        for (int n = 0; n < 150; n++) begin
            int          sel;
            int          r1;
            int          r2;
            logic [15:0] iv;
            sel = $urandom_range(0, 99);
            if (sel < 4)      iv = {3'b111, 13'($urandom)};
            else if (sel < 8) iv = {bad_keys[$urandom_range(0, 5)], 11'($urandom)};
            else              iv = {good_keys[$urandom_range(0, 7)], 11'($urandom)};
            r1 = $urandom_range(0, 19);
            r2 = $urandom_range(0, 19);
            run_instr(iv,
                      (r1 == 0) ? MAX_WAIT + 1 : (r1 == 1) ? MAX_WAIT : $urandom_range(0, 3),
                      (r2 == 0) ? MAX_WAIT + 1 : (r2 == 1) ? MAX_WAIT : $urandom_range(0, 3),
                      ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1);
        end
        @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
